// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the instruction-memory loader
package mips_pkg;

   localparam int INSTR_W        = 32;
   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      CHECK,
      DONE,
      ERROR
   } loader_state_t;

endpackage

// File: rtl/byte_assembler.sv
// rtl/byte_assembler.sv - packs a byte stream big-endian into 32-bit words
module byte_assembler
   import mips_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic               clear,
   input  logic               in_valid,
   input  logic [7:0]         in_byte,
   output logic               word_valid,
   output logic [INSTR_W-1:0] word
);

   logic [1:0]  r_cnt;
   logic [23:0] r_shift;

   // The word completes on the fourth byte itself, so the FSM can act on the same edge.
   assign word_valid = in_valid && (r_cnt == 2'(BYTES_PER_WORD - 1));
   assign word       = {r_shift, in_byte};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cnt   <= '0;
         r_shift <= '0;
      end else if (clear) begin
         r_cnt   <= '0;
         r_shift <= '0;
      end else if (in_valid) begin
         r_cnt   <= r_cnt + 2'd1;
         r_shift <= {r_shift[15:0], in_byte};
      end
   end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a checksummed program into instruction memory, holding the CPU
module imem_loader
   import mips_pkg::*;
#(
   parameter int                WORDS     = 9,
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               byte_valid,
   input  logic [7:0]         byte_data,
   output logic               byte_ready,
   output logic               wr_en,
   output logic [ADDR_W-1:0]  wr_addr,
   output logic [INSTR_W-1:0] wr_data,
   output logic               cpu_hold,
   output logic               load_done,
   output logic               load_err
);

   localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   loader_state_t      r_state, w_next;
   logic [CNT_W-1:0]   r_wcnt;
   logic [ADDR_W-1:0]  r_next_addr;
   logic [INSTR_W-1:0] r_acc;
   logic               r_wr_en;
   logic [ADDR_W-1:0]  r_wr_addr;
   logic [INSTR_W-1:0] r_wr_data;

   logic               w_accept;
   logic               w_clear;
   logic               w_word_valid;
   logic [INSTR_W-1:0] w_word;
   logic               w_word_in_load;

   assign byte_ready     = (r_state == LOAD) || (r_state == CHECK);
   assign w_accept       = byte_valid && byte_ready;
   assign w_clear        = start && (r_state == IDLE || r_state == DONE || r_state == ERROR);
   assign w_word_in_load = w_word_valid && (r_state == LOAD);

   byte_assembler u_asm (
      .clock      (clock),
      .reset      (reset),
      .clear      (w_clear),
      .in_valid   (w_accept),
      .in_byte    (byte_data),
      .word_valid (w_word_valid),
      .word       (w_word)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE, DONE, ERROR: if (start) w_next = LOAD;
         LOAD:  if (w_word_valid && r_wcnt == CNT_W'(WORDS - 1)) w_next = CHECK;
         CHECK: if (w_word_valid) w_next = (w_word == r_acc) ? DONE : ERROR;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wcnt      <= '0;
         r_next_addr <= '0;
         r_acc       <= '0;
         r_wr_en     <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
      end else begin
         r_wr_en <= w_word_in_load;
         if (w_clear) begin
            r_wcnt      <= '0;
            r_next_addr <= BASE_ADDR;
            r_acc       <= '0;
         end else if (w_word_in_load) begin
            r_wcnt      <= r_wcnt + CNT_W'(1);
            r_next_addr <= r_next_addr + ADDR_W'(BYTES_PER_WORD);
            r_acc       <= r_acc ^ w_word;
            r_wr_addr   <= r_next_addr;
            r_wr_data   <= w_word;
         end
      end
   end

   assign wr_en     = r_wr_en;
   assign wr_addr   = r_wr_addr;
   assign wr_data   = r_wr_data;
   assign cpu_hold  = (r_state != DONE);
   assign load_done = (r_state == DONE);
   assign load_err  = (r_state == ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;

   logic        byte_ready, wr_en, cpu_hold, load_done, load_err;
   logic [31:0] wr_addr, wr_data;
   logic        b_ready, b_wr_en, b_hold, b_done, b_err;
   logic [31:0] b_addr, b_data;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_wr    = 0;
   logic [31:0] q_addr[$];
   logic [31:0] q_data[$];
   logic [31:0] q_addr_b[$];

   logic [7:0]  good_stream [12] = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'h01, 8'h09, 8'h50, 8'h20,
                                     8'h8D, 8'h08, 8'h50, 8'h24};

   always #5 clock = ~clock;

   imem_loader #(.WORDS(2), .ADDR_W(32), .BASE_ADDR(32'h0)) dut (
      .clock(clock), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
      .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
   );

   imem_loader #(.WORDS(2), .ADDR_W(32), .BASE_ADDR(32'h20)) dut_b (
      .clock(clock), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
      .byte_ready(b_ready), .wr_en(b_wr_en), .wr_addr(b_addr), .wr_data(b_data),
      .cpu_hold(b_hold), .load_done(b_done), .load_err(b_err)
   );

   always @(negedge clock) begin
      if (wr_en) begin
         n_wr++;
         q_addr.push_back(wr_addr);
         q_data.push_back(wr_data);
      end
      if (b_wr_en) q_addr_b.push_back(b_addr);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      byte_data  = b;
      byte_valid = 1'b1;
      @(negedge clock);
      byte_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic send_stream(input logic [31:0] csum, input bit gaps);
      logic [7:0] b;
      for (int i = 0; i < 12; i++) begin
         b = (i < 8) ? good_stream[i] : csum[31 - 8*(i-8) -: 8];
         send(b);
         if (gaps) repeat ($urandom_range(0, 2)) @(negedge clock);
         if (gaps && i == 2) pulse_start();
      end
   endtask

   task automatic clear_q();
      q_addr.delete();
      q_data.delete();
      q_addr_b.delete();
   endtask

   task automatic check_writes(input string tag);
      check_eq({tag, "_nwr"}, q_addr.size(), 2);
      if (q_addr.size() == 2) begin
         check_eq({tag, "_a0"}, q_addr[0], 32'h0);
         check_eq({tag, "_d0"}, q_data[0], 32'h8C010004);
         check_eq({tag, "_a1"}, q_addr[1], 32'h4);
         check_eq({tag, "_d1"}, q_data[1], 32'h01095020);
      end
   endtask

   initial begin
      int wr_before;
      repeat (3) @(negedge clock);
      check_eq("rst_ready", byte_ready, 0);
      check_eq("rst_wr_en", wr_en, 0);
      check_eq("rst_addr", wr_addr, 0);
      check_eq("rst_data", wr_data, 0);
      check_eq("rst_hold", cpu_hold, 1);
      check_eq("rst_done", load_done, 0);
      check_eq("rst_err", load_err, 0);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      check_eq("idle_ready", byte_ready, 0);
      check_eq("idle_hold", cpu_hold, 1);

      // bytes in IDLE must be ignored
      wr_before = n_wr;
      for (int i = 0; i < 6; i++) send(8'hA5);
      repeat (2) @(negedge clock);
      check_eq("idle_bytes_nwr", n_wr - wr_before, 0);

      // good load, no gaps
      clear_q();
      pulse_start();
      check_eq("start_ready", byte_ready, 1);
      send_stream(32'h8D085024, 1'b0);
      check_eq("good_done", load_done, 1);
      check_eq("good_hold", cpu_hold, 0);
      check_eq("good_ready", byte_ready, 0);
      repeat (2) @(negedge clock);
      check_writes("good");
      check_eq("good_wr_hold", wr_data, 32'h01095020);

      // bytes in DONE must be ignored
      wr_before = n_wr;
      for (int i = 0; i < 5; i++) send(8'h3C);
      repeat (2) @(negedge clock);
      check_eq("done_bytes_nwr", n_wr - wr_before, 0);
      check_eq("done_still", load_done, 1);

      // bad checksum
      clear_q();
      pulse_start();
      check_eq("bad_load_done", load_done, 0);
      check_eq("bad_load_hold", cpu_hold, 1);
      send_stream(32'h0, 1'b0);
      check_eq("bad_err", load_err, 1);
      check_eq("bad_done", load_done, 0);
      check_eq("bad_hold", cpu_hold, 1);
      repeat (2) @(negedge clock);
      check_writes("bad");
      pulse_start();
      check_eq("restart_err", load_err, 0);
      check_eq("restart_ready", byte_ready, 1);

      // gaps and a mid-load start on the load just started
      clear_q();
      send_stream(32'h8D085024, 1'b1);
      repeat (2) @(negedge clock);
      check_eq("gap_done", load_done, 1);
      check_eq("gap_hold", cpu_hold, 0);
      check_writes("gap");

      // reset after 6 accepted bytes
      pulse_start();
      for (int i = 0; i < 6; i++) send(good_stream[i]);
      reset = 1'b1;
      #1;
      check_eq("mid_rst_ready", byte_ready, 0);
      check_eq("mid_rst_addr", wr_addr, 0);
      check_eq("mid_rst_data", wr_data, 0);
      check_eq("mid_rst_hold", cpu_hold, 1);
      check_eq("mid_rst_b_addr", b_addr, 0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      // full load after reset; second instance is based at 0x20
      clear_q();
      pulse_start();
      send_stream(32'h8D085024, 1'b0);
      repeat (2) @(negedge clock);
      check_eq("post_rst_done", load_done, 1);
      check_eq("post_rst_b_done", b_done, 1);
      check_writes("post_rst");
      check_eq("base_nwr", q_addr_b.size(), 2);
      if (q_addr_b.size() == 2) begin
         check_eq("base_a0", q_addr_b[0], 32'h20);
         check_eq("base_a1", q_addr_b[1], 32'h24);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
